// File: rtl/mem_stage_ctrl.sv
// mem_stage_ctrl: MEM-stage data-memory handshake FSM that stalls the pipeline during an access
// and bubbles MEM/WB until the access completes, with a sticky timeout error.
module mem_stage_ctrl #(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_W          = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             exmem_memread,
    input  logic             exmem_memwrite,
    input  logic [31:0]      exmem_addr,
    input  logic [31:0]      exmem_wdata,
    output logic             mem_req,
    output logic             mem_we,
    output logic [31:0]      mem_addr,
    output logic [31:0]      mem_wdata,
    input  logic             mem_ready,
    input  logic [31:0]      mem_rdata,
    output logic             stall_o,
    output logic             memwb_bubble_o,
    output logic [31:0]      rdata_o,
    output logic             err_o,
    output logic [CNT_W-1:0] stall_cnt_o
);
    typedef enum logic [1:0] {IDLE, REQ, DONE, ERR} state_t;
    localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WW:0] TO = TIMEOUT_CYCLES[WW:0];
    state_t state, state_nxt;
    logic [WW-1:0] wait_cnt;
    logic [WW:0] wait_inc;
    logic access, timeout;
    assign access   = exmem_memread | exmem_memwrite;
    assign wait_inc = {1'b0, wait_cnt} + 1'b1;
    // the REQ cycle that would push the count to TIMEOUT_CYCLES is the last one allowed
    assign timeout  = wait_inc >= TO;
    always_comb begin
        state_nxt      = state;
        stall_o        = 1'b0;
        memwb_bubble_o = 1'b0;
        case (state)
            IDLE: begin
                stall_o        = access;
                memwb_bubble_o = access;
                state_nxt      = access ? REQ : IDLE;
            end
            REQ: begin
                stall_o        = 1'b1;
                memwb_bubble_o = 1'b1;
                state_nxt      = mem_ready ? DONE : (timeout ? ERR : REQ);
            end
            DONE: state_nxt = IDLE;
            ERR: begin
                stall_o        = 1'b1;
                memwb_bubble_o = 1'b1;
            end
        endcase
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            rdata_o     <= '0;
            err_o       <= 1'b0;
            stall_cnt_o <= '0;
            wait_cnt    <= '0;
        end else begin
            state <= state_nxt;
            if (stall_o && stall_cnt_o != '1)
                stall_cnt_o <= stall_cnt_o + 1'b1;
            if (state == IDLE && access) begin
                mem_req   <= 1'b1;
                mem_we    <= exmem_memwrite;
                mem_addr  <= exmem_addr;
                mem_wdata <= exmem_wdata;
                wait_cnt  <= '0;
            end
            if (state == REQ) begin
                if (mem_ready) begin
                    mem_req <= 1'b0;
                    if (!mem_we)
                        rdata_o <= mem_rdata;
                end else if (timeout) begin
                    mem_req <= 1'b0;
                    err_o   <= 1'b1;
                end else begin
                    wait_cnt <= wait_inc[WW-1:0];
                end
            end
        end
    end
endmodule

// File: tb/tb_mem_stage_ctrl.sv
// tb_mem_stage_ctrl: directed checks of the MEM-stage controller with hand-computed expectations.
module tb_mem_stage_ctrl;
    logic clk = 1'b0, rst = 1'b0, rd = 1'b0, wr = 1'b0, rdy = 1'b0;
    logic [31:0] addr = '0, wdata = '0, rdata = '0;
    logic mem_req, mem_we, stall_o, memwb_bubble_o, err_o;
    logic [31:0] mem_addr, mem_wdata, rdata_o;
    logic [3:0] stall_cnt_o;
    int errs = 0, checks = 0;

    mem_stage_ctrl #(.TIMEOUT_CYCLES(4), .CNT_W(4)) dut (
        .clk(clk), .rst(rst),
        .exmem_memread(rd), .exmem_memwrite(wr), .exmem_addr(addr), .exmem_wdata(wdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ready(rdy), .mem_rdata(rdata),
        .stall_o(stall_o), .memwb_bubble_o(memwb_bubble_o), .rdata_o(rdata_o),
        .err_o(err_o), .stall_cnt_o(stall_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drv(input int r, input int w, input logic [31:0] a, input logic [31:0] d,
                       input int y, input logic [31:0] q);
        @(posedge clk);
        #1;
        rd = (r != 0); wr = (w != 0); addr = a; wdata = d; rdy = (y != 0); rdata = q;
        #1;
    endtask

    initial begin
        int exp_stall [6] = '{1, 1, 0, 1, 1, 0};
        int pat_rdy [6]   = '{0, 1, 0, 0, 1, 0};
        logic [31:0] pat_addr [6]  = '{'h40, 'h40, 'h40, 'h44, 'h44, 'h44};
        logic [31:0] pat_rdata [6] = '{0, 'h11, 0, 0, 'h22, 0};
        repeat (2) @(posedge clk);
        #1;
        chk("rst_mem_req", 32'(mem_req), 0);
        chk("rst_mem_we", 32'(mem_we), 0);
        chk("rst_err", 32'(err_o), 0);
        chk("rst_cnt", 32'(stall_cnt_o), 0);
        chk("rst_rdata", rdata_o, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_stall", 32'(stall_o), 0);
        rst = 1'b1;

        // single load, ready on first REQ cycle
        drv(1, 0, 'h10, 0, 0, 0);
        chk("ld_idle_stall", 32'(stall_o), 1);
        chk("ld_idle_bubble", 32'(memwb_bubble_o), 1);
        chk("ld_idle_req", 32'(mem_req), 0);
        drv(1, 0, 'h10, 0, 1, 'hDEADBEEF);
        chk("ld_req", 32'(mem_req), 1);
        chk("ld_addr", mem_addr, 'h10);
        chk("ld_we", 32'(mem_we), 0);
        chk("ld_req_stall", 32'(stall_o), 1);
        drv(1, 0, 'h10, 0, 0, 0);
        chk("ld_done_stall", 32'(stall_o), 0);
        chk("ld_done_bubble", 32'(memwb_bubble_o), 0);
        chk("ld_rdata", rdata_o, 'hDEADBEEF);
        chk("ld_done_req", 32'(mem_req), 0);
        chk("ld_cnt", 32'(stall_cnt_o), 2);
        drv(0, 0, 0, 0, 0, 0);
        chk("ld_after_stall", 32'(stall_o), 0);
        chk("ld_after_req", 32'(mem_req), 0);

        // store, ready on third REQ cycle
        drv(0, 1, 'h20, 'h12345678, 0, 0);
        chk("st_idle_stall", 32'(stall_o), 1);
        for (int i = 0; i < 3; i++) begin
            drv(0, 1, 'h20, 'h12345678, int'(i == 2), 'hAAAA5555);
            chk("st_we", 32'(mem_we), 1);
            chk("st_addr", mem_addr, 'h20);
            chk("st_wdata", mem_wdata, 'h12345678);
            chk("st_req", 32'(mem_req), 1);
            chk("st_stall", 32'(stall_o), 1);
        end
        drv(0, 1, 'h20, 'h12345678, 0, 0);
        chk("st_done_stall", 32'(stall_o), 0);
        chk("st_rdata_kept", rdata_o, 'hDEADBEEF);
        chk("st_cnt", 32'(stall_cnt_o), 6);

        // async reset clears counter and load data immediately
        drv(0, 0, 0, 0, 0, 0);
        rst = 1'b0;
        #1;
        chk("arst_cnt", 32'(stall_cnt_o), 0);
        chk("arst_rdata", rdata_o, 0);
        rst = 1'b1;

        // back-to-back loads
        for (int i = 0; i < 6; i++) begin
            drv(1, 0, pat_addr[i], 0, pat_rdy[i], pat_rdata[i]);
            chk("b2b_stall", 32'(stall_o), exp_stall[i]);
            chk("b2b_bubble", 32'(memwb_bubble_o), exp_stall[i]);
            if (i == 2) chk("b2b_rdata1", rdata_o, 'h11);
        end
        chk("b2b_rdata2", rdata_o, 'h22);
        chk("b2b_addr2", mem_addr, 'h44);
        chk("b2b_cnt", 32'(stall_cnt_o), 4);

        // read and write both set: treated as a write
        drv(1, 1, 'h50, 'hCAFE, 0, 0);
        drv(1, 1, 'h50, 'hCAFE, 1, 'h99);
        chk("rw_we", 32'(mem_we), 1);
        chk("rw_wdata", mem_wdata, 'hCAFE);
        drv(1, 1, 'h50, 'hCAFE, 0, 0);
        chk("rw_rdata_kept", rdata_o, 'h22);
        drv(0, 0, 0, 0, 0, 0);

        // ready arriving on the last allowed REQ cycle completes normally
        drv(1, 0, 'h60, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            drv(1, 0, 'h60, 0, int'(i == 3), 'h77);
            chk("edge_req", 32'(mem_req), 1);
        end
        drv(1, 0, 'h60, 0, 0, 0);
        chk("edge_err", 32'(err_o), 0);
        chk("edge_stall", 32'(stall_o), 0);
        chk("edge_rdata", rdata_o, 'h77);
        drv(0, 0, 0, 0, 0, 0);

        // timeout into ERR
        drv(1, 0, 'h70, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            drv(1, 0, 'h70, 0, 0, 0);
            chk("to_req", 32'(mem_req), 1);
            chk("to_err_low", 32'(err_o), 0);
        end
        drv(1, 0, 'h70, 0, 0, 0);
        chk("err_flag", 32'(err_o), 1);
        chk("err_req", 32'(mem_req), 0);
        chk("err_stall", 32'(stall_o), 1);
        chk("err_bubble", 32'(memwb_bubble_o), 1);
        drv(0, 0, 0, 0, 1, 'h55);
        chk("err_sticky", 32'(err_o), 1);
        chk("err_stall_held", 32'(stall_o), 1);
        chk("err_rdata_kept", rdata_o, 'h77);
        rst = 1'b0;
        #1;
        chk("err_rst_flag", 32'(err_o), 0);
        chk("err_rst_stall", 32'(stall_o), 0);
        rst = 1'b1;
        drv(0, 0, 0, 0, 0, 0);
        chk("err_rst_idle", 32'(stall_o), 0);

        // reset in the second REQ cycle, then stray ready
        drv(1, 0, 'h80, 0, 0, 0);
        drv(1, 0, 'h80, 0, 0, 0);
        drv(0, 0, 0, 0, 0, 0);
        chk("mid_req_before", 32'(mem_req), 1);
        rst = 1'b0;
        #1;
        chk("mid_rst_req", 32'(mem_req), 0);
        chk("mid_rst_stall", 32'(stall_o), 0);
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            drv(0, 0, 0, 0, 1, 'h66);
            chk("stray_req", 32'(mem_req), 0);
            chk("stray_stall", 32'(stall_o), 0);
            chk("stray_rdata", rdata_o, 0);
        end

        // long ERR stall drives the counter to saturation
        drv(1, 0, 'h90, 0, 0, 0);
        repeat (20) drv(0, 0, 0, 0, 0, 0);
        chk("sat_cnt", 32'(stall_cnt_o), 'hF);
        chk("sat_err", 32'(err_o), 1);
        drv(0, 0, 0, 0, 0, 0);
        chk("sat_hold", 32'(stall_cnt_o), 'hF);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule

// File: doc/mem_stage_ctrl.md
MEM_STAGE_CTRL -- requirements
Module: mem_stage_ctrl

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 64: max REQ cycles to wait for mem_ready before error.
REQ-002 Parameter CNT_W, default 16: width of the stall performance counter.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 exmem_memread  input  1  EX/MEM instruction is a load.
REQ-006 exmem_memwrite  input  1  EX/MEM instruction is a store.
REQ-007 exmem_addr  input  32  EX/MEM ALU result, used as the data address.
REQ-008 exmem_wdata  input  32  EX/MEM store data.
REQ-009 mem_req  output  1  registered request to data memory.
REQ-010 mem_we  output  1  registered write enable; valid while mem_req=1.
REQ-011 mem_addr  output  32  registered address; stable while mem_req=1.
REQ-012 mem_wdata  output  32  registered write data; stable while mem_req=1.
REQ-013 mem_ready  input  1  memory completion; sampled only in REQ.
REQ-014 mem_rdata  input  32  read data; valid when mem_ready=1.
REQ-015 stall_o  output  1  holds PC, IF/ID, ID/EX and EX/MEM registers.
REQ-016 memwb_bubble_o  output  1  forces MEM/WB RegWrite, MemtoReg and Write inputs to 0.
REQ-017 rdata_o  output  32  latched load data driven to MEM/WB Readata input.
REQ-018 err_o  output  1  sticky memory timeout flag.
REQ-019 stall_cnt_o  output  CNT_W  count of cycles with stall_o=1.

Function
REQ-020 The FSM SHALL have exactly four states: IDLE, REQ, DONE and ERR.
REQ-021 access SHALL equal exmem_memread OR exmem_memwrite; if both are 1, the access SHALL be a write (mem_we=1).
REQ-022 In IDLE with access=0, stall_o and memwb_bubble_o SHALL be 0 and the state SHALL stay IDLE.
REQ-023 In IDLE with access=1, stall_o=1 and memwb_bubble_o=1 combinationally.
REQ-024 On the next edge, the FSM SHALL go to REQ and latch mem_addr, mem_wdata and mem_we, and set mem_req=1.
REQ-025 In REQ, stall_o=1, memwb_bubble_o=1 and mem_req=1; mem_addr, mem_wdata and mem_we SHALL not change.
REQ-026 In REQ with mem_ready=1, on that edge: rdata_o <= mem_rdata for a read (unchanged for a write), mem_req <= 0, go to DONE.
REQ-027 In DONE, stall_o=0 and memwb_bubble_o=0 so the pipeline advances one instruction; the next state SHALL always be IDLE, with no re-trigger on the same instruction.
REQ-028 Latency: with mem_ready first high in the k-th REQ cycle (k>=1), stall_o SHALL be high for exactly k+1 cycles, followed by 1 DONE cycle.
REQ-029 A wait counter SHALL clear on entry to REQ and increment each REQ cycle without mem_ready.
REQ-030 If the wait counter reaches TIMEOUT_CYCLES, the FSM SHALL go to ERR with mem_req <= 0 and err_o <= 1.
REQ-031 ERR SHALL be terminal until reset: stall_o=1, memwb_bubble_o=1, mem_req=0, err_o=1.
REQ-032 mem_ready SHALL be ignored in IDLE, DONE and ERR.
REQ-033 mem_ready=1 in the same cycle the counter reaches TIMEOUT_CYCLES SHALL complete normally (ready wins).
REQ-034 stall_cnt_o SHALL increment on each edge where stall_o=1 and SHALL saturate at all-ones.
REQ-035 Back-to-back accesses (access=1 in the IDLE cycle after DONE) SHALL start a new access with no idle gap.

Reset
REQ-036 On rst=0, the FSM SHALL go to IDLE immediately, regardless of state, including mid-REQ and ERR.
REQ-037 On rst=0, these outputs SHALL clear: mem_req, mem_we, err_o -> 0; mem_addr, mem_wdata, rdata_o -> 0; stall_cnt_o -> 0; wait counter -> 0.
REQ-038 After reset release, stall_o and memwb_bubble_o SHALL depend only on IDLE and access.

Verification
REQ-039 Load at 0x0000_0010, mem_ready on 1st REQ cycle with rdata 0xDEAD_BEEF -> stall 2 cycles, DONE with rdata_o=0xDEAD_BEEF, stall_cnt_o=2.
REQ-040 Store at 0x0000_0020 with wdata 0x1234_5678, ready on 3rd REQ cycle -> mem_we=1, address/data stable 3 cycles, stall 4 cycles, rdata_o unchanged.
REQ-041 Two loads back-to-back, ready immediately -> pattern stall 1,1,0,1,1,0; two DONE pulses; stall_cnt_o=4.
REQ-042 memread=memwrite=1 -> mem_we=1 for the access.
REQ-043 TIMEOUT_CYCLES=4, mem_ready never asserted -> ERR after 4 REQ cycles, err_o=1, mem_req=0, stall held; rst pulse returns to IDLE with err_o=0.
REQ-044 rst asserted in 2nd REQ cycle -> mem_req=0 and stall_o=0 (access=0) immediately; later mem_ready ignored; stall_cnt_o forced to all-ones value stays saturated on further stalls.
